// File: rtl/serial_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter and its "101" tracker.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        S_NONE,
        S_1,
        S_10,
        S_101
    } seq_state_t;

    localparam logic [2:0] SEQ_PATTERN = 3'b101;
    localparam int         REP_W       = 4;

endpackage

// File: rtl/serial_pattern_tx_seq101_tracker.sv
// Overlapping "101" detector over the transmitted bit stream; built only when
// SERIAL_PATTERN_TX_HITCNT_EN is defined (the transmitter instantiates it under the same macro).
`ifdef SERIAL_PATTERN_TX_HITCNT_EN
module seq101_tracker
    import serial_pattern_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic hit
);

    seq_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q <= S_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // S_101 keeps its trailing "1", so a following 0 continues into the "10" prefix.
    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (bit_valid) begin
            case (state_q)
                S_NONE: state_d = (bit_in == SEQ_PATTERN[2]) ? S_1 : S_NONE;
                S_1:    state_d = (bit_in == SEQ_PATTERN[1]) ? S_10 : S_1;
                S_10: begin
                    if (bit_in == SEQ_PATTERN[0]) begin
                        state_d = S_101;
                        hit     = 1'b1;
                    end else begin
                        state_d = S_NONE;
                    end
                end
                S_101:  state_d = (bit_in == SEQ_PATTERN[1]) ? S_10 : S_1;
                default: state_d = S_NONE;
            endcase
        end
    end

endmodule
`endif

// File: rtl/serial_pattern_tx.sv
// Serial MSB-first word transmitter with repeat count and valid/ready load port.
// Optional "101" hit counter enabled by defining SERIAL_PATTERN_TX_HITCNT_EN.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [REP_W-1:0] load_rep,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       hit_count
);

    localparam int CNT_W = $clog2(WIDTH);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             x_q, x_valid_q, busy_q, done_q, ready_q;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == IDLE) && load_valid;
    assign last_bit = (bit_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = load_data;
                    shift_d = load_data;
                    rep_d   = load_rep;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                bit_d   = bit_q + 1'b1;
                // Reload from the hold copy on the word's last bit so repetitions run gap-free.
                if (last_bit) begin
                    if (rep_q != '0) begin
                        rep_d   = rep_q - 1'b1;
                        shift_d = hold_q;
                        bit_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so every port comes straight off a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            x_q       <= (state_d == SHIFT) ? shift_d[WIDTH-1] : IDLE_BIT;
            x_valid_q <= (state_d == SHIFT);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            ready_q   <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
        bit_q   <= bit_d;
        rep_q   <= rep_d;
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

`ifdef SERIAL_PATTERN_TX_HITCNT_EN
    logic       hit;
    logic [7:0] hit_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    seq101_tracker u_tracker (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept),
        .bit_valid (state_q == SHIFT),
        .bit_in    (shift_q[WIDTH-1]),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            hit_q <= 8'd0;
        end else if (hit) begin
            hit_q <= sat_inc(hit_q);
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = 8'd0;
`endif

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-pattern transmitter that produces the one-bit-per-clock stream consumed by the team's serial sequence detectors. It accepts a parallel word and a repeat count through a valid/ready load port, then shifts the word out MSB-first, back-to-back, for the requested number of repetitions. It can optionally track its own "101" (overlapping) occurrences so a bench can cross-check the detector's hit count.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- IDLE_BIT, 1'b0, level driven on `x` whenever `x_valid` is low.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE; load accepted when `load_valid && load_ready`.
- load_data  in  WIDTH  word to transmit, MSB first.
- load_rep  in  4  extra repetitions; total transmissions = `load_rep+1` (1..16).
- x  out  1  serial bit, registered.
- x_valid  out  1  high while `x` carries a pattern bit.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse after the last bit.
- hit_count  out  8  saturating count of "101" occurrences emitted; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `load_ready`=1.
  - On accept: capture `load_data` into the hold register and the shift register, `load_rep` into the repeat counter, and clear the bit counter to 0. Go to SHIFT.
- SHIFT:
  - `x` = shift-register MSB and `x_valid`=1.
  - Each cycle the register shifts left by one and the bit counter increments.
  - On bit index WIDTH-1:
    - If the repeat counter is nonzero: decrement it, reload the shift register from the hold register, clear the bit counter, and stay in SHIFT. There are no gap cycles between repetitions.
    - Otherwise go to DONE.
- DONE: `done`=1, `x_valid`=0, `x`=IDLE_BIT. Next cycle go to IDLE.
- `load_valid` while not in IDLE is ignored. It is not queued.
- `hit_count` holds its value until the next accept. It clears to 0 on accept, not on DONE.
- Reset, including mid-transfer, takes effect at the next edge and aborts the transfer. No `done` pulse is produced for an aborted transfer.
- Reset values: `load_ready`=1, `x`=IDLE_BIT, `x_valid`=0, `busy`=0, `done`=0, `hit_count`=0, state IDLE.

## Timing
- Accept at edge N gives the first bit on `x` and `x_valid` from N+1.
- A transfer lasts `WIDTH*(load_rep+1)` bit cycles. The last bit is at N+WIDTH*(load_rep+1).
- `done` is high exactly one cycle, immediately after the last bit.
- `load_ready` returns high the cycle after `done`. The minimum accept-to-accept spacing is `WIDTH*(load_rep+1)+2` cycles.
- All outputs are registered. There is no combinational path from inputs to outputs except none; `load_ready` depends on state only.

## Configuration
- SERIAL_PATTERN_TX_HITCNT_EN defined:
  - A 4-state "101" tracker observes each bit with `x_valid`=1.
  - Overlap rules: after a hit, a following 0 continues the "10" prefix. After "1", a further 1 keeps the tracker at "1".
  - On each hit, `hit_count` increments, saturating at 255.
  - The tracker state clears on reset and on accept. It is continuous across repetition boundaries.
  - Idle bits are never observed.
- Undefined: the tracker is not built and `hit_count` is tied to 8'd0. The port is still present.

## Structure
- Package `serial_pattern_pkg` contains:
  - state enum `tx_state_t` (IDLE, SHIFT, DONE);
  - tracker enum `seq_state_t` (S_NONE, S_1, S_10, S_101);
  - constant `SEQ_PATTERN = 3'b101`;
  - constant `REP_W = 4`.
- One sub-module, `seq101_tracker` (clk, reset, clr, bit_valid, bit_in, hit). It is instantiated only under SERIAL_PATTERN_TX_HITCNT_EN.

## Test plan
- Reset, then idle 5 cycles: `load_ready`=1, `x_valid`=0, `x`=0, `busy`=0, `hit_count`=0 throughout.
- Load 8'hB5, rep=0, accepted at N:
  - `x` = 1,0,1,1,0,1,0,1 on N+1..N+8.
  - `done` at N+9 and `load_ready` at N+10.
  - `hit_count`=3 with the macro, 0 without.
- Load 8'hA5, rep=1:
  - 16 contiguous valid bits 10100101 10100101 with no gap, and `done` at N+17.
  - `hit_count`=4, which confirms that no hit spans the boundary "01|10".
- Pulse `load_valid` with 8'hFF during SHIFT of an 8'h0F transfer: the transfer is unaffected and the second word is never emitted.
- Reset asserted at N+4 of an 8'hB5 transfer: the next cycle shows all outputs at reset values and no `done` pulse. A fresh load then transmits correctly.
- Load 8'h55 (WIDTH=8), rep=15:
  - 128 bits are emitted.
  - Each word contributes 3 hits and each boundary ("01|01") contributes 1, giving 48+15=63, so `hit_count`=63.
  - Repeat 5 back-to-back transfers without clearing: `hit_count` reads 63 after each, because it clears on accept.
